// File: rtl/ndw_pkg.sv
// ndw_pkg: shared state encoding and leaf-count helper for the wide frame NAND pipe
package ndw_pkg;
  typedef enum logic {FST_IDLE, FST_ACCUM} fst_e;
  function automatic int leaves(int w, int l);
    return (w + l - 1) / l;
  endfunction
endpackage

// File: rtl/ndw_frame_pipe_if.sv
// ndw_frame_pipe_if: beat input bus and frame result outputs of the wide NAND pipe
interface ndw_frame_pipe_if #(parameter int WIDTH = 26);
  logic [WIDTH-1:0] a;
  logic in_vld;
  logic in_first;
  logic in_last;
  logic q;
  logic q_vld;
  logic busy;
  logic err;
  modport master (output a, in_vld, in_first, in_last, input q, q_vld, busy, err);
  modport slave (input a, in_vld, in_first, in_last, output q, q_vld, busy, err);
endinterface

// File: rtl/ndw_leaf.sv
// ndw_leaf: registered LEAF-wide AND; bits at or above VALID are forced to 1
module ndw_leaf #(
  parameter int LEAF = 8,
  parameter int VALID = LEAF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LEAF-1:0] d,
  output logic            y
);
  logic [LEAF-1:0] pad;
  always_comb begin
    for (int i = 0; i < LEAF; i++) pad[i] = (i >= VALID);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) y <= 1'b1;
    else y <= &(d | pad);
endmodule

// File: rtl/ndw_frame_pipe.sv
// ndw_frame_pipe: pipelined wide NAND reduction accumulated over in_first/in_last framed beats.
// ND_OUT_REG_EN adds one output register on q, q_vld and err.
module ndw_frame_pipe
  import ndw_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int LEAF = 8
) (
  input logic sys_clk,
  input logic resetl,
  ndw_frame_pipe_if.slave bus
);
  localparam int LEAVES = leaves(WIDTH, LEAF);
  logic [LEAVES*LEAF-1:0] a_ext;
  logic [LEAVES-1:0] leaf;
  logic s1_vld, s1_first, s1_last;
  logic acc, acc_n, open, q_s, q_vld_s, err_s;
  fst_e state;
  always_comb begin
    a_ext = '0;
    a_ext[WIDTH-1:0] = bus.a;
  end
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    ndw_leaf #(
      .LEAF(LEAF),
      .VALID((WIDTH - i*LEAF) >= LEAF ? LEAF : WIDTH - i*LEAF)
    ) u_leaf (
      .clk(sys_clk),
      .rst_n(resetl),
      .d(a_ext[i*LEAF +: LEAF]),
      .y(leaf[i])
    );
  end
  // A first beat always opens a frame, discarding whatever was accumulating.
  always_comb begin
    open = s1_first | (state == FST_ACCUM);
    acc_n = (s1_first | acc) & (&leaf);
  end
  always_ff @(posedge sys_clk or negedge resetl)
    if (!resetl) begin
      s1_vld <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      state <= FST_IDLE;
      acc <= 1'b1;
      q_s <= 1'b1;
      q_vld_s <= 1'b0;
      err_s <= 1'b0;
    end else begin
      s1_vld <= bus.in_vld;
      s1_first <= bus.in_first;
      s1_last <= bus.in_last;
      q_vld_s <= 1'b0;
      err_s <= 1'b0;
      if (s1_vld) begin
        err_s <= s1_first ? (state == FST_ACCUM) : (state == FST_IDLE);
        if (open && s1_last) begin
          q_s <= ~acc_n;
          q_vld_s <= 1'b1;
          acc <= 1'b1;
          state <= FST_IDLE;
        end else if (open) begin
          acc <= acc_n;
          state <= FST_ACCUM;
        end
      end
    end
  assign bus.busy = (state == FST_ACCUM) | s1_vld;
`ifdef ND_OUT_REG_EN
  logic q_o, q_vld_o, err_o;
  always_ff @(posedge sys_clk or negedge resetl)
    if (!resetl) begin
      q_o <= 1'b1;
      q_vld_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      q_o <= q_s;
      q_vld_o <= q_vld_s;
      err_o <= err_s;
    end
  assign bus.q = q_o;
  assign bus.q_vld = q_vld_o;
  assign bus.err = err_o;
`else
  assign bus.q = q_s;
  assign bus.q_vld = q_vld_s;
  assign bus.err = err_s;
`endif
endmodule

// File: tb/tb_ndw_frame_pipe.sv
// tb_ndw_frame_pipe: directed frame sequences against hand-computed NAND results
module tb_ndw_frame_pipe;
`ifdef ND_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [25:0] ONES = 26'h3FFFFFF;
  logic sys_clk = 1'b0;
  logic resetl = 1'b0;
  int checks = 0;
  int errors = 0;
  int nerr = 0;
  logic qs[$];
  ndw_frame_pipe_if #(.WIDTH(26)) bus ();
  ndw_frame_pipe #(.WIDTH(26), .LEAF(8)) dut (
    .sys_clk(sys_clk),
    .resetl(resetl),
    .bus(bus.slave)
  );
  always #5 sys_clk = ~sys_clk;
  always @(negedge sys_clk) begin
    if (bus.q_vld === 1'b1) qs.push_back(bus.q);
    if (bus.err === 1'b1) nerr++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [25:0] a, input logic f, input logic l);
    bus.a = a;
    bus.in_vld = 1'b1;
    bus.in_first = f;
    bus.in_last = l;
    @(posedge sys_clk);
    #1;
    bus.in_vld = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    bus.a = '0;
  endtask
  task automatic settle();
    repeat (LAT + 2) @(posedge sys_clk);
    #1;
  endtask
  task automatic clear();
    qs.delete();
    nerr = 0;
  endtask
  task automatic expect_frames(input string tag, input int n, input logic q0, input logic q1, input int e);
    chk({tag, "_count"}, qs.size(), n);
    if (n > 0) chk({tag, "_q0"}, {31'd0, qs[0]}, {31'd0, q0});
    if (n > 1) chk({tag, "_q1"}, {31'd0, qs[1]}, {31'd0, q1});
    chk({tag, "_err"}, nerr, e);
    clear();
  endtask
  initial begin
    bus.a = '0;
    bus.in_vld = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_q", bus.q, 1);
    chk("rst_qvld", bus.q_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    resetl = 1'b1;
    @(posedge sys_clk);
    #1;
    send(ONES, 1, 1);
    chk("t1_qvld_early", bus.q_vld, 0);
    chk("t1_busy", bus.busy, 1);
    repeat (LAT - 2) begin
      @(posedge sys_clk);
      #1;
      chk("t1_qvld_wait", bus.q_vld, 0);
    end
    @(posedge sys_clk);
    #1;
    chk("t1_qvld", bus.q_vld, 1);
    chk("t1_q", bus.q, 0);
    chk("t1_err", bus.err, 0);
    @(posedge sys_clk);
    #1;
    chk("t1_pulse", bus.q_vld, 0);
    chk("t1_hold_q", bus.q, 0);
    settle();
    clear();
    send(26'h3FFFFFE, 1, 1);
    settle();
    expect_frames("t2_bit0", 1, 1, 0, 0);
    send(ONES, 1, 0);
    send(26'h3FFDFFF, 0, 0);
    send(ONES, 0, 1);
    send(ONES, 1, 0);
    send(ONES, 0, 0);
    send(ONES, 0, 1);
    settle();
    expect_frames("t3_b2b", 2, 1, 0, 0);
    send(26'h0, 1, 0);
    send(ONES, 1, 0);
    send(ONES, 0, 1);
    settle();
    expect_frames("t4_abort", 1, 0, 0, 1);
    send(ONES, 0, 1);
    send(26'h3FFFF7F, 1, 1);
    settle();
    expect_frames("t5_stray", 1, 1, 0, 1);
    send(ONES, 1, 0);
    bus.in_first = 1'b1;
    bus.in_last = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    chk("hold_busy", bus.busy, 1);
    send(26'h3FFFFDF, 0, 1);
    settle();
    expect_frames("hold_vld", 1, 1, 0, 0);
    send(ONES, 1, 0);
    send(ONES, 0, 0);
    #3;
    resetl = 1'b0;
    #1;
    chk("t6_q", bus.q, 1);
    chk("t6_qvld", bus.q_vld, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_err", bus.err, 0);
    @(negedge sys_clk);
    resetl = 1'b1;
    @(posedge sys_clk);
    #1;
    clear();
    send(ONES, 0, 1);
    settle();
    expect_frames("t6_after", 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
